gem_rx_link_align: RTL and testbench

- Multi-channel, fabric-clock-domain back end for GEM optical receivers. Sits after the per-fiber GTX receivers, once their data is already in the 40 MHz clock domain.
- Per channel it runs a link-quality state machine and counts link errors.
- Data from links that are not GOOD is forced to zero, so bad fibers cannot inject hot pads.
- Each channel has its own programmable 0..DEPTH-1 bx delay from a circular buffer, so fibers of unequal length can be aligned before cluster finding.

---
 rtl/gem_link_pkg.sv | 21 ++
 rtl/gem_link_monitor.sv | 141 ++++++++++++++
 rtl/gem_rx_link_align.sv | 110 +++++++++++
 tb/tb_gem_rx_link_align.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gem_link_pkg.sv
// Shared definitions for the GEM receive link-alignment block.
// Contents: link FSM state encoding, error-counter width and saturation value,
// and a saturating-increment helper for the error counter.
package gem_link_pkg;

  // Link-quality FSM state encoding
  typedef logic [1:0] link_state_t;
  localparam link_state_t StDown  = 2'd0;
  localparam link_state_t StCheck = 2'd1;
  localparam link_state_t StGood  = 2'd2;
  localparam link_state_t StBad   = 2'd3;

  // Per-channel error counter
  localparam int unsigned ErrCntW = 16;
  localparam logic [ErrCntW-1:0] ErrCntMax = 16'hFFFF;

  function automatic logic [ErrCntW-1:0] err_cnt_inc(input logic [ErrCntW-1:0] cnt);
    return (cnt == ErrCntMax) ? cnt : cnt + 16'd1;
  endfunction

endpackage

// File: rtl/gem_link_monitor.sv
// One channel of link-quality monitoring.
// Runs the DOWN/CHECK/GOOD/BAD link FSM, the clean-bx and error-window counters,
// the saturating error counter and the sticky had-error flag.
// Ports:
//   clock, rst_n      fabric clock, synchronous active-low reset
//   ttc_resync        clears counter and sticky flag, releases BAD to CHECK
//   sync_done         GTX sync complete for this channel
//   err_in            link error this bx
//   link_good         registered decode of state == GOOD
//   link_bad          registered decode of state == BAD
//   link_had_err      sticky error flag
//   err_count         saturating error count
module gem_link_monitor
  import gem_link_pkg::*;
#(
  parameter logic [7:0] GOOD_THR  = 8'd255,
  parameter logic [9:0] WIN       = 10'd1023,
  parameter logic [7:0] ERR_LIMIT = 8'd4
) (
  input  logic               clock,
  input  logic               rst_n,
  input  logic               ttc_resync,
  input  logic               sync_done,
  input  logic               err_in,
  output logic               link_good,
  output logic               link_bad,
  output logic               link_had_err,
  output logic [ErrCntW-1:0] err_count
);

  link_state_t        state_q, state_d;
  logic [7:0]         clean_q, clean_d;
  logic [9:0]         win_q, win_d;
  logic [7:0]         werr_q, werr_d;
  logic [ErrCntW-1:0] cnt_q, cnt_d;
  logic               had_q, had_d;
  logic               good_q, good_d;
  logic               bad_q, bad_d;

  logic       win_wrap;
  logic [7:0] werr_inc;
  logic [7:0] clean_inc;

  always_comb begin
    state_d = state_q;
    clean_d = clean_q;
    win_d   = win_q;
    werr_d  = werr_q;

    win_wrap  = (win_q == WIN - 10'd1);
    // An error on the wrap cycle belongs to the new window
    werr_inc  = (win_wrap ? 8'd0 : werr_q) + {7'd0, err_in};
    clean_inc = clean_q + 8'd1;

    if (!sync_done) begin
      state_d = StDown;
    end else if (ttc_resync && (state_q == StBad)) begin
      state_d = StCheck;
      clean_d = '0;
    end else begin
      unique case (state_q)
        StDown: begin
          state_d = StCheck;
          clean_d = '0;
        end
        StCheck: begin
          if (err_in) begin
            clean_d = '0;
          end else begin
            clean_d = clean_inc;
            if (clean_inc == GOOD_THR) begin
              state_d = StGood;
              win_d   = '0;
              werr_d  = '0;
            end
          end
        end
        StGood: begin
          win_d  = win_wrap ? 10'd0 : win_q + 10'd1;
          werr_d = werr_inc;
          if (werr_inc >= ERR_LIMIT) begin
            state_d = StBad;
          end
        end
        StBad: begin
          state_d = StBad;
        end
        default: begin
          state_d = StDown;
        end
      endcase
    end
  end

  // Resync wins over a same-cycle error
  always_comb begin
    cnt_d = cnt_q;
    had_d = had_q;
    if (ttc_resync) begin
      cnt_d = '0;
      had_d = 1'b0;
    end else if (sync_done && err_in) begin
      cnt_d = err_cnt_inc(cnt_q);
      had_d = 1'b1;
    end
  end

  // Flags decode the current state, so they trail the transition by one clock
  always_comb begin
    good_d = (state_q == StGood);
    bad_d  = (state_q == StBad);
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state_q <= StDown;
      clean_q <= '0;
      win_q   <= '0;
      werr_q  <= '0;
      cnt_q   <= '0;
      had_q   <= 1'b0;
      good_q  <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      clean_q <= clean_d;
      win_q   <= win_d;
      werr_q  <= werr_d;
      cnt_q   <= cnt_d;
      had_q   <= had_d;
      good_q  <= good_d;
      bad_q   <= bad_d;
    end
  end

  assign link_good    = good_q;
  assign link_bad     = bad_q;
  assign link_had_err = had_q;
  assign err_count    = cnt_q;

endmodule

// File: rtl/gem_rx_link_align.sv
// Multi-channel GEM receive back end in the 40 MHz fabric domain.
// Per channel: link-quality monitor, masking of data from links that are not
// GOOD, and a programmable 0..DEPTH-1 bx delay from a circular buffer.
// Ports:
//   clock, rst_n   fabric clock, synchronous active-low reset
//   ttc_resync     clears counters/sticky flags, releases BAD to CHECK
//   sync_done      per-channel GTX sync complete
//   err_in         per-channel link error this bx
//   data_in        per-channel word, ch i at [i*DW +: DW]
//   delay          per-channel bx delay, ch i at [i*AW +: AW]
//   data_out       masked, delayed data
//   link_good      per-channel state == GOOD
//   link_bad       per-channel state == BAD
//   link_had_err   per-channel sticky error flag
//   err_count      per-channel saturating error count, ch i at [i*16 +: 16]
//   sump           OR of otherwise unused bits
module gem_rx_link_align
  import gem_link_pkg::*;
#(
  parameter int unsigned NCH       = 4,
  parameter int unsigned DW        = 56,
  parameter int unsigned AW        = 4,
  parameter logic [7:0]  GOOD_THR  = 8'd255,
  parameter logic [9:0]  WIN       = 10'd1023,
  parameter logic [7:0]  ERR_LIMIT = 8'd4
) (
  input  logic                   clock,
  input  logic                   rst_n,
  input  logic                   ttc_resync,
  input  logic [NCH-1:0]         sync_done,
  input  logic [NCH-1:0]         err_in,
  input  logic [NCH*DW-1:0]      data_in,
  input  logic [NCH*AW-1:0]      delay,
  output logic [NCH*DW-1:0]      data_out,
  output logic [NCH-1:0]         link_good,
  output logic [NCH-1:0]         link_bad,
  output logic [NCH-1:0]         link_had_err,
  output logic [NCH*ErrCntW-1:0] err_count,
  output logic                   sump
);

  localparam int unsigned Depth = 2 ** AW;

  // Write pointer shared by all channel buffers
  logic [AW-1:0] wptr_q, wptr_d;

  always_comb begin
    wptr_d = wptr_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      wptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [DW-1:0] masked;
    logic [AW-1:0] ch_delay;
    logic [AW-1:0] rd_idx;
    logic [DW-1:0] mem_q [Depth];
    logic [DW-1:0] dout_q, dout_d;

    gem_link_monitor #(
      .GOOD_THR  (GOOD_THR),
      .WIN       (WIN),
      .ERR_LIMIT (ERR_LIMIT)
    ) u_mon (
      .clock        (clock),
      .rst_n        (rst_n),
      .ttc_resync   (ttc_resync),
      .sync_done    (sync_done[i]),
      .err_in       (err_in[i]),
      .link_good    (link_good[i]),
      .link_bad     (link_bad[i]),
      .link_had_err (link_had_err[i]),
      .err_count    (err_count[i*ErrCntW +: ErrCntW])
    );

    // Registered link_good gates the word, so bad fibers inject only zeros
    always_comb begin
      masked   = link_good[i] ? data_in[i*DW +: DW] : '0;
      ch_delay = delay[i*AW +: AW];
      rd_idx   = wptr_q - ch_delay;
      // rd_idx never equals wptr_q for a non-zero delay, so read-before-write is safe
      dout_d   = (ch_delay == '0) ? masked : mem_q[rd_idx];
    end

    // Buffer is cleared on reset so stale words cannot reappear afterwards
    always_ff @(posedge clock) begin
      if (!rst_n) begin
        for (int k = 0; k < Depth; k++) begin
          mem_q[k] <= '0;
        end
        dout_q <= '0;
      end else begin
        mem_q[wptr_q] <= masked;
        dout_q        <= dout_d;
      end
    end

    assign data_out[i*DW +: DW] = dout_q;
  end

  // Every input is consumed in this configuration
  assign sump = 1'b0;

endmodule

// File: tb/tb_gem_rx_link_align.sv
// Self-checking bench for gem_rx_link_align: randomized stimulus plus directed
// scenarios, compared every cycle against a behavioural model.
module tb_gem_rx_link_align;

  localparam int NCH   = 4;
  localparam int DW    = 56;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  localparam int S_DOWN  = 0;
  localparam int S_CHECK = 1;
  localparam int S_GOOD  = 2;
  localparam int S_BAD   = 3;

  logic              clock = 1'b0;
  logic              rst_n;
  logic              ttc_resync;
  logic [NCH-1:0]    sync_done;
  logic [NCH-1:0]    err_in;
  logic [NCH*DW-1:0] data_in;
  logic [NCH*AW-1:0] delay;
  logic [NCH*DW-1:0] data_out;
  logic [NCH-1:0]    link_good;
  logic [NCH-1:0]    link_bad;
  logic [NCH-1:0]    link_had_err;
  logic [NCH*16-1:0] err_count;
  logic              sump;

  int n_checks = 0;
  int n_errors = 0;

  gem_rx_link_align u_dut (
    .clock        (clock),
    .rst_n        (rst_n),
    .ttc_resync   (ttc_resync),
    .sync_done    (sync_done),
    .err_in       (err_in),
    .data_in      (data_in),
    .delay        (delay),
    .data_out     (data_out),
    .link_good    (link_good),
    .link_bad     (link_bad),
    .link_had_err (link_had_err),
    .err_count    (err_count),
    .sump         (sump)
  );

  always #12 clock = ~clock;

  // Behavioural model state
  int          m_st    [NCH];
  int          m_clean [NCH];
  int          m_win   [NCH];
  int          m_werr  [NCH];
  int          m_cnt   [NCH];
  bit          m_had   [NCH];
  bit          m_good  [NCH];
  bit          m_bad   [NCH];
  logic [DW-1:0] m_dout [NCH];
  logic [DW-1:0] m_hist [NCH][$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic [DW-1:0] masked;
    int d;
    bit sd, e;
    if (!rst_n) begin
      for (int ch = 0; ch < NCH; ch++) begin
        m_st[ch] = S_DOWN; m_clean[ch] = 0; m_win[ch] = 0; m_werr[ch] = 0;
        m_cnt[ch] = 0; m_had[ch] = 0; m_good[ch] = 0; m_bad[ch] = 0;
        m_dout[ch] = '0;
        m_hist[ch].delete();
      end
      return;
    end
    for (int ch = 0; ch < NCH; ch++) begin
      sd = sync_done[ch];
      e  = err_in[ch];
      masked = m_good[ch] ? data_in[ch*DW +: DW] : '0;
      d = int'(delay[ch*AW +: AW]);
      // Word written d bx ago, or zero if nothing was written that long ago
      if (d == 0) m_dout[ch] = masked;
      else if (m_hist[ch].size() >= d) m_dout[ch] = m_hist[ch][m_hist[ch].size() - d];
      else m_dout[ch] = '0;
      m_hist[ch].push_back(masked);
      if (m_hist[ch].size() > DEPTH) void'(m_hist[ch].pop_front());

      m_good[ch] = (m_st[ch] == S_GOOD);
      m_bad[ch]  = (m_st[ch] == S_BAD);

      if (ttc_resync) begin
        m_cnt[ch] = 0; m_had[ch] = 0;
      end else if (sd && e) begin
        if (m_cnt[ch] < 65535) m_cnt[ch]++;
        m_had[ch] = 1;
      end

      if (!sd) m_st[ch] = S_DOWN;
      else if (ttc_resync && m_st[ch] == S_BAD) begin
        m_st[ch] = S_CHECK; m_clean[ch] = 0;
      end else begin
        case (m_st[ch])
          S_DOWN: begin m_st[ch] = S_CHECK; m_clean[ch] = 0; end
          S_CHECK: begin
            if (e) m_clean[ch] = 0;
            else begin
              m_clean[ch]++;
              if (m_clean[ch] == 255) begin
                m_st[ch] = S_GOOD; m_win[ch] = 0; m_werr[ch] = 0;
              end
            end
          end
          S_GOOD: begin
            if (m_win[ch] == 1022) begin m_win[ch] = 0; m_werr[ch] = 0; end
            else m_win[ch]++;
            if (e) m_werr[ch]++;
            if (m_werr[ch] >= 4) m_st[ch] = S_BAD;
          end
          default: ;
        endcase
      end
    end
  endtask

  task automatic check_all();
    for (int ch = 0; ch < NCH; ch++) begin
      check_eq($sformatf("data_out[%0d]", ch), 64'(data_out[ch*DW +: DW]), 64'(m_dout[ch]));
      check_eq($sformatf("link_good[%0d]", ch), 64'(link_good[ch]), 64'(m_good[ch]));
      check_eq($sformatf("link_bad[%0d]", ch), 64'(link_bad[ch]), 64'(m_bad[ch]));
      check_eq($sformatf("link_had_err[%0d]", ch), 64'(link_had_err[ch]), 64'(m_had[ch]));
      check_eq($sformatf("err_count[%0d]", ch), 64'(err_count[ch*16 +: 16]), 64'(m_cnt[ch]));
    end
    check_eq("sump", 64'(sump), 64'(0));
  endtask

  // Inputs are stable here; model and DUT both see them at the next posedge
  task automatic cyc();
    model_edge();
    @(posedge clock);
    @(negedge clock);
    check_all();
  endtask

  task automatic rand_data();
    logic [63:0] r;
    for (int ch = 0; ch < NCH; ch++) begin
      r = {$urandom(), $urandom()};
      data_in[ch*DW +: DW] = r[DW-1:0];
    end
  endtask

  logic [DW-1:0] sent3 [$];
  logic [DW-1:0] mark;
  int lat [NCH];

  initial begin
    rst_n = 1'b0; ttc_resync = 1'b0; sync_done = '0; err_in = '0; data_in = '0;
    delay = {4'd15, 4'd7, 4'd1, 4'd0};
    lat[0] = 1; lat[1] = 2; lat[2] = 8; lat[3] = 16;
    repeat (3) cyc();
    check_eq("rst_good", 64'(link_good), 64'(0));
    check_eq("rst_cnt", 64'(err_count), 64'(0));

    // Bring all links up with clean data
    rst_n = 1'b1;
    sync_done = '1;
    for (int k = 1; k <= 256; k++) begin
      rand_data();
      cyc();
    end
    check_eq("good0_pre", 64'(link_good[0]), 64'(0));
    check_eq("dout0_pre", 64'(data_out[DW-1:0]), 64'(0));
    rand_data();
    cyc();
    check_eq("good0_rise", 64'(link_good[0]), 64'(1));

    // Marker through each delay
    data_in = '0;
    repeat (4) cyc();
    for (int ch = 0; ch < NCH; ch++) begin
      mark = 56'h00C0FFEE000000 + 56'(ch + 1);
      data_in[ch*DW +: DW] = mark;
    end
    for (int k = 1; k <= 17; k++) begin
      cyc();
      data_in = '0;
      for (int ch = 0; ch < NCH; ch++) begin
        mark = 56'h00C0FFEE000000 + 56'(ch + 1);
        if (k == lat[ch]) check_eq($sformatf("marker%0d", ch), 64'(data_out[ch*DW +: DW]), 64'(mark));
      end
    end

    // ch3 delay 15 -> 2 mid-stream
    for (int k = 0; k < 20; k++) begin
      rand_data();
      sent3.push_back(data_in[3*DW +: DW]);
      cyc();
    end
    delay[3*AW +: AW] = 4'd2;
    for (int k = 0; k < 10; k++) begin
      rand_data();
      sent3.push_back(data_in[3*DW +: DW]);
      cyc();
      check_eq("dly_change3", 64'(data_out[3*DW +: DW]), 64'(sent3[sent3.size() - 3]));
    end

    // ch1: four errors in one window -> BAD, then resync
    for (int k = 0; k < 100; k++) begin
      rand_data();
      err_in = '0;
      err_in[1] = (k % 25 == 5);
      cyc();
    end
    err_in = '0;
    check_eq("bad1", 64'(link_bad[1]), 64'(1));
    check_eq("cnt1", 64'(err_count[16 +: 16]), 64'(4));
    check_eq("dout1_masked", 64'(data_out[DW +: DW]), 64'(0));
    ttc_resync = 1'b1;
    cyc();
    ttc_resync = 1'b0;
    check_eq("cnt1_resync", 64'(err_count[16 +: 16]), 64'(0));
    check_eq("had1_resync", 64'(link_had_err[1]), 64'(0));
    cyc();
    check_eq("bad1_release", 64'(link_bad[1]), 64'(0));

    // ch2: three errors per window, ch3 random errors and delays
    for (int k = 0; k < 3069; k++) begin
      rand_data();
      err_in = '0;
      err_in[2] = (k % 341 == 100);
      err_in[3] = ($urandom_range(0, 299) == 0);
      if (k % 50 == 0) delay[3*AW +: AW] = 4'($urandom_range(0, 15));
      cyc();
    end
    err_in = '0;
    check_eq("good2_3win", 64'(link_good[2]), 64'(1));
    check_eq("cnt2_3win", 64'(err_count[32 +: 16]), 64'(9));

    // ch0: error held high to saturation
    err_in[0] = 1'b1;
    for (int k = 0; k < 70000; k++) cyc();
    check_eq("cnt0_sat", 64'(err_count[15:0]), 64'hFFFF);
    ttc_resync = 1'b1;
    cyc();
    ttc_resync = 1'b0;
    err_in = '0;
    check_eq("cnt0_resync_wins", 64'(err_count[15:0]), 64'(0));
    check_eq("had0_resync_wins", 64'(link_had_err[0]), 64'(0));

    // Reset while ch2 GOOD
    check_eq("good2_prerst", 64'(link_good[2]), 64'(1));
    delay = {4'd3, 4'd5, 4'd2, 4'd1};
    data_in = '1;
    cyc();
    data_in = '0;
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    check_eq("rst_dout", 64'(|data_out), 64'(0));
    check_eq("rst_link_good", 64'(link_good), 64'(0));
    check_eq("rst_err_count", 64'(|err_count), 64'(0));
    for (int k = 0; k < 20; k++) begin
      cyc();
      check_eq("post_rst_dout", 64'(|data_out), 64'(0));
    end

    // Random phase
    for (int k = 0; k < 1500; k++) begin
      rand_data();
      for (int ch = 0; ch < NCH; ch++) begin
        sync_done[ch] = ($urandom_range(0, 299) != 0);
        err_in[ch]    = ($urandom_range(0, 399) == 0);
      end
      ttc_resync = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 19) == 0) delay[$urandom_range(0, NCH-1)*AW +: AW] = 4'($urandom_range(0, 15));
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
